demux_fifo_l2: RTL
==================

Name: demux_fifo_l2

Overview:
- Downstream consumer of the two-level 4:1 mux tree.
- Receives the serialized 8-bit stream it produces, where lane words arrive interleaved in order 0,1,2,3 on consecutive valid cycles.
- Deinterleaves the stream back into four lanes and buffers each lane in its own FIFO, each with an independent pop interface.
- Single clock domain; sits on the lane-2 output clock of the mux tree.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, entries per lane FIFO; must be a power of 2, minimum 2.
- AF_THRESH, 3, occupancy at or above which a lane counts toward almost_full; range 1..DEPTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- valid_in  input  1  data_in carries a lane word this cycle.
- data_in  input  WIDTH  serialized word from data_out_l2 of the mux tree.
- pop0..pop3  input  1 each  read request for lane i.
- data_out0..data_out3  output  WIDTH each  registered head word of lane i.
- valid_out0..valid_out3  output  1 each  data_out_i is new this cycle.
- empty0..empty3  output  1 each  lane i FIFO holds 0 entries.
- full0..full3  output  1 each  lane i FIFO holds DEPTH entries.
- almost_full  output  1  any lane occupancy is >= AF_THRESH.
- error  output  1  sticky overflow flag.

Behaviour:
- Reset (reset_L=0, takes effect immediately, independent of clk):
  - lane pointer lp=0; all FIFO read/write pointers and counts = 0.
  - data_out*=0, valid_out*=0, error=0.
  - empty*=1, full*=0, almost_full=0.
- Reset asserted mid-operation discards all buffered words. First valid word after release goes to lane 0.
- Write path, on each clk edge with valid_in=1:
  - Target lane is lp.
  - If FIFO[lp] is not full, or is full and is popped this same cycle: store data_in at the write pointer, then advance the write pointer (wraps modulo DEPTH).
  - If FIFO[lp] is full and not popped: drop the word and set error=1. error is sticky and clears only on reset.
  - lp <= lp+1, wrapping 3->0. lp advances even on a dropped word so lane alignment is preserved.
  - valid_in=0: lp holds and nothing is written.
- Read path, per lane i, on each clk edge:
  - pop_i=1 and FIFO i not empty: data_out_i <= head entry, valid_out_i <= 1, read pointer advances.
  - pop_i=1 while empty: ignored, valid_out_i <= 0, no error raised.
  - pop_i=0: valid_out_i <= 0; data_out_i holds its last value.
  - Read latency is 1 cycle from pop to valid_out.
- Simultaneous push and pop on the same lane:
  - When full: both occur, count stays DEPTH, no error.
  - When empty: the push is stored, the pop is ignored (no fall-through), count becomes 1.
- Count update per lane: +1 on accepted push only, -1 on effective pop only, unchanged on both or neither.
- Flags:
  - empty_i = (count_i==0); full_i = (count_i==DEPTH).
  - almost_full = OR over i of (count_i >= AF_THRESH).
  - All flags are combinational from registered counts, so they reflect state after the last edge.
- Four lanes are independent; pops on different lanes in the same cycle are all serviced.
- Count registers are log2(DEPTH)+1 bits wide.

Test Plan:
- Reset: assert reset_L=0 mid-clock -> all outputs at reset values immediately; empty0..3=1, error=0.
- Deinterleave: valid_in=1 for 8 cycles with data 0x10,0x21,0x32,0x43,0x14,0x25,0x36,0x47, then pop0 for 2 cycles -> data_out0=0x10 then 0x14 with valid_out0=1, each 1 cycle after pop; lanes 1..3 hold count 2.
- Overflow: 20 valid words with no pops (DEPTH=4) -> full0..3=1 after word 16, words 17..20 dropped, error=1 and remains 1 until reset; the 4 words in lane 0 are words 1,5,9,13.
- Full lane with push+pop: lane 0 full, lp=0, valid_in=1 data 0xAA with pop0=1 -> no error, count0 stays 4, 0xAA becomes the tail entry.
- Empty pop and push: all lanes empty, pop0=1 with valid_in=1 data 0x5C at lp=0 -> valid_out0=0 next cycle, empty0=0; pop0 on the following cycle -> data_out0=0x5C.
- almost_full: push 3 words into lane 2 only (lp walking, lanes 0/1/3 popped each time) -> almost_full=1 exactly when count2 reaches 3; pop2 once -> almost_full=0.

Source files
------------

// File: rtl/demux_fifo_l2.sv
`default_nettype none
// ============================================================================
// demux_fifo_l2 : splits an interleaved 4-lane word stream into 4 lane FIFOs
// Revision      : 1.0
// ============================================================================
module demux_fifo_l2 #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int AF_THRESH = 3
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] data_in,
   input  logic             pop0,
   input  logic             pop1,
   input  logic             pop2,
   input  logic             pop3,
   output logic [WIDTH-1:0] data_out0,
   output logic [WIDTH-1:0] data_out1,
   output logic [WIDTH-1:0] data_out2,
   output logic [WIDTH-1:0] data_out3,
   output logic             valid_out0,
   output logic             valid_out1,
   output logic             valid_out2,
   output logic             valid_out3,
   output logic             empty0,
   output logic             empty1,
   output logic             empty2,
   output logic             empty3,
   output logic             full0,
   output logic             full1,
   output logic             full2,
   output logic             full3,
   output logic             almost_full,
   output logic             error
);

   localparam int            c_aw    = $clog2(DEPTH);
   localparam int            c_cw    = c_aw + 1;
   localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);
   localparam logic [c_cw-1:0] c_af    = c_cw'(AF_THRESH);

   logic [1:0] r_lp;
   logic       r_error;
   logic [3:0] w_pop;
   logic [3:0] w_full;
   logic [3:0] w_empty;
   logic [3:0] w_af;
   logic       w_drop;

   assign w_pop = {pop3, pop2, pop1, pop0};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [WIDTH-1:0] r_mem [DEPTH];
         logic [c_aw-1:0]  r_wr_ptr;
         logic [c_aw-1:0]  r_rd_ptr;
         logic [c_cw-1:0]  r_count;
         logic [WIDTH-1:0] r_data_out;
         logic             r_valid_out;
         logic             w_empty_l;
         logic             w_full_l;
         logic             w_rd;
         logic             w_push;

         assign w_empty_l = (r_count == '0);
         assign w_full_l  = (r_count == c_depth);
         assign w_rd      = w_pop[gi] && !w_empty_l;
         // A full lane still accepts a push when its head leaves in the same cycle.
         assign w_push    = valid_in && (r_lp == 2'(gi)) && (!w_full_l || w_rd);

         always_ff @(posedge clk) begin
            if (w_push) begin
               r_mem[r_wr_ptr] <= data_in;
            end
         end

         always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
               r_wr_ptr    <= '0;
               r_rd_ptr    <= '0;
               r_count     <= '0;
               r_data_out  <= '0;
               r_valid_out <= 1'b0;
            end else begin
               if (w_push) begin
                  r_wr_ptr <= r_wr_ptr + c_aw'(1);
               end
               if (w_rd) begin
                  r_rd_ptr   <= r_rd_ptr + c_aw'(1);
                  r_data_out <= r_mem[r_rd_ptr];
               end
               r_valid_out <= w_rd;
               if (w_push && !w_rd) begin
                  r_count <= r_count + c_cw'(1);
               end else if (w_rd && !w_push) begin
                  r_count <= r_count - c_cw'(1);
               end
            end
         end
      end
   endgenerate

   assign w_empty = {g_lane[3].w_empty_l, g_lane[2].w_empty_l, g_lane[1].w_empty_l, g_lane[0].w_empty_l};
   assign w_full  = {g_lane[3].w_full_l,  g_lane[2].w_full_l,  g_lane[1].w_full_l,  g_lane[0].w_full_l};
   assign w_af    = {g_lane[3].r_count >= c_af, g_lane[2].r_count >= c_af,
                     g_lane[1].r_count >= c_af, g_lane[0].r_count >= c_af};

   // A full lane is never empty, so a pop on it is always effective.
   assign w_drop = valid_in && w_full[r_lp] && !w_pop[r_lp];

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_lp    <= 2'd0;
         r_error <= 1'b0;
      end else begin
         if (valid_in) begin
            r_lp <= r_lp + 2'd1;
         end
         if (w_drop) begin
            r_error <= 1'b1;
         end
      end
   end

   assign data_out0   = g_lane[0].r_data_out;
   assign data_out1   = g_lane[1].r_data_out;
   assign data_out2   = g_lane[2].r_data_out;
   assign data_out3   = g_lane[3].r_data_out;
   assign valid_out0  = g_lane[0].r_valid_out;
   assign valid_out1  = g_lane[1].r_valid_out;
   assign valid_out2  = g_lane[2].r_valid_out;
   assign valid_out3  = g_lane[3].r_valid_out;
   assign empty0      = w_empty[0];
   assign empty1      = w_empty[1];
   assign empty2      = w_empty[2];
   assign empty3      = w_empty[3];
   assign full0       = w_full[0];
   assign full1       = w_full[1];
   assign full2       = w_full[2];
   assign full3       = w_full[3];
   assign almost_full = |w_af;
   assign error       = r_error;

endmodule
`default_nettype wire
